// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue path: opcode classes, the decinst codes the ALU executes,
// the issue FSM state encoding and the captured write-back record.
package alu_pkg;

    localparam logic [6:0] BRANCH_OPC = 7'b1100011;
    localparam logic [6:0] OP_OPC     = 7'b0110011;
    localparam logic [6:0] OPIMM_OPC  = 7'b0010011;
    localparam logic [6:0] LUI_OPC    = 7'b0110111;
    localparam logic [6:0] AUIPC_OPC  = 7'b0010111;

    // decinst = {1'b0, funct7[5], funct3, opcode}
    localparam logic [11:0] DI_ADD   = {1'b0, 1'b0, 3'b000, OP_OPC};
    localparam logic [11:0] DI_SUB   = {1'b0, 1'b1, 3'b000, OP_OPC};
    localparam logic [11:0] DI_SLL   = {1'b0, 1'b0, 3'b001, OP_OPC};
    localparam logic [11:0] DI_SLT   = {1'b0, 1'b0, 3'b010, OP_OPC};
    localparam logic [11:0] DI_SLTU  = {1'b0, 1'b0, 3'b011, OP_OPC};
    localparam logic [11:0] DI_XOR   = {1'b0, 1'b0, 3'b100, OP_OPC};
    localparam logic [11:0] DI_SRL   = {1'b0, 1'b0, 3'b101, OP_OPC};
    localparam logic [11:0] DI_SRA   = {1'b0, 1'b1, 3'b101, OP_OPC};
    localparam logic [11:0] DI_OR    = {1'b0, 1'b0, 3'b110, OP_OPC};
    localparam logic [11:0] DI_AND   = {1'b0, 1'b0, 3'b111, OP_OPC};
    localparam logic [11:0] DI_ADDI  = {1'b0, 1'b0, 3'b000, OPIMM_OPC};
    localparam logic [11:0] DI_SLTI  = {1'b0, 1'b0, 3'b010, OPIMM_OPC};
    localparam logic [11:0] DI_SLTIU = {1'b0, 1'b0, 3'b011, OPIMM_OPC};
    localparam logic [11:0] DI_XORI  = {1'b0, 1'b0, 3'b100, OPIMM_OPC};
    localparam logic [11:0] DI_ORI   = {1'b0, 1'b0, 3'b110, OPIMM_OPC};
    localparam logic [11:0] DI_ANDI  = {1'b0, 1'b0, 3'b111, OPIMM_OPC};
    localparam logic [11:0] DI_SLLI  = {1'b0, 1'b0, 3'b001, OPIMM_OPC};
    localparam logic [11:0] DI_SRLI  = {1'b0, 1'b0, 3'b101, OPIMM_OPC};
    localparam logic [11:0] DI_SRAI  = {1'b0, 1'b1, 3'b101, OPIMM_OPC};
    localparam logic [11:0] DI_BEQ   = {1'b0, 1'b0, 3'b000, BRANCH_OPC};
    localparam logic [11:0] DI_BNE   = {1'b0, 1'b0, 3'b001, BRANCH_OPC};
    localparam logic [11:0] DI_BLT   = {1'b0, 1'b0, 3'b100, BRANCH_OPC};
    localparam logic [11:0] DI_BGE   = {1'b0, 1'b0, 3'b101, BRANCH_OPC};
    localparam logic [11:0] DI_BLTU  = {1'b0, 1'b0, 3'b110, BRANCH_OPC};
    localparam logic [11:0] DI_BGEU  = {1'b0, 1'b0, 3'b111, BRANCH_OPC};
    // AUIPC relies on register-read muxing the PC onto rs1
    localparam logic [11:0] DI_LUI   = {1'b0, 1'b0, 3'b000, LUI_OPC};
    localparam logic [11:0] DI_AUIPC = {1'b0, 1'b0, 3'b000, AUIPC_OPC};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        we;
        logic        carry;
        logic        br;
        logic        err;
    } wb_t;

    function automatic logic is_branch(input logic [11:0] di);
        return di[6:0] == BRANCH_OPC;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// One-at-a-time ALU sequencer: accept -> LOAD (en low) -> EXEC (en high until done/timeout) -> DONE.
// Minimum 4 cycles per instruction; DONE holds wb_* stable and blocks new work until wb_ready.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int TIMEOUT = 31,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [11:0] decinst,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm_data,
    input  logic [4:0]  rd_addr,
    output logic        alu_en,
    output logic [11:0] alu_decinst,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    output logic [31:0] alu_imm,
    input  logic [31:0] alu_rd,
    input  logic        alu_cmp,
    input  logic        alu_carry,
    input  logic        alu_is_rd,
    input  logic        alu_is_inst,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_addr,
    output logic        wb_we,
    output logic        wb_carry,
    output logic        br_taken,
    output logic        wb_err
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    generate
        if (TIMEOUT < 16 || (64'd1 << CNT_W) <= 64'(TIMEOUT)) begin : g_param_chk
            $error("alu_issue_ctrl: TIMEOUT must be >= 16 and fit in CNT_W bits");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               inst_ready_q, inst_ready_d;
    logic               alu_en_q, alu_en_d;
    logic [11:0]        decinst_q, decinst_d;
    logic [31:0]        rs1_q, rs1_d;
    logic [31:0]        rs2_q, rs2_d;
    logic [31:0]        imm_q, imm_d;
    logic [4:0]         rd_q, rd_d;
    logic               wb_valid_q, wb_valid_d;
    wb_t                wb_q, wb_d;

    logic               br_inst;
    logic               exec_hit;

    assign br_inst  = is_branch(decinst_q);
    // Branches never raise is_rd, so they complete on is_inst alone
    assign exec_hit = br_inst ? alu_is_inst : (alu_is_inst & alu_is_rd);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        inst_ready_d = inst_ready_q;
        alu_en_d     = alu_en_q;
        decinst_d    = decinst_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        imm_d        = imm_q;
        rd_d         = rd_q;
        wb_valid_d   = wb_valid_q;
        wb_d         = wb_q;

        case (state_q)
            IDLE: begin
                if (inst_valid && inst_ready_q) begin
                    decinst_d    = decinst;
                    rs1_d        = rs1_data;
                    rs2_d        = rs2_data;
                    imm_d        = imm_data;
                    rd_d         = rd_addr;
                    inst_ready_d = 1'b0;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                cnt_d    = '0;
                alu_en_d = 1'b1;
                state_d  = EXEC;
            end
            EXEC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (exec_hit) begin
                    // alu_rd is only looked at here, when the ALU is known to drive it
                    wb_d.data  = br_inst ? 32'd0 : alu_rd;
                    wb_d.addr  = rd_q;
                    wb_d.we    = !br_inst && (rd_q != 5'd0);
                    wb_d.carry = alu_carry;
                    wb_d.br    = br_inst & alu_cmp;
                    wb_d.err   = 1'b0;
                    alu_en_d   = 1'b0;
                    wb_valid_d = 1'b1;
                    state_d    = DONE;
                end else if (cnt_q == TO_CNT) begin
                    wb_d.data  = 32'd0;
                    wb_d.addr  = rd_q;
                    wb_d.we    = 1'b0;
                    wb_d.carry = 1'b0;
                    wb_d.br    = 1'b0;
                    wb_d.err   = 1'b1;
                    alu_en_d   = 1'b0;
                    wb_valid_d = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (wb_ready) begin
                    wb_valid_d   = 1'b0;
                    inst_ready_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            inst_ready_q <= 1'b1;
            alu_en_q     <= 1'b0;
            decinst_q    <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            imm_q        <= '0;
            rd_q         <= '0;
            wb_valid_q   <= 1'b0;
            wb_q         <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            inst_ready_q <= inst_ready_d;
            alu_en_q     <= alu_en_d;
            decinst_q    <= decinst_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            imm_q        <= imm_d;
            rd_q         <= rd_d;
            wb_valid_q   <= wb_valid_d;
            wb_q         <= wb_d;
        end
    end

    assign inst_ready  = inst_ready_q;
    assign alu_en      = alu_en_q;
    assign alu_decinst = decinst_q;
    assign alu_rs1     = rs1_q;
    assign alu_rs2     = rs2_q;
    assign alu_imm     = imm_q;
    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_q.data;
    assign wb_addr     = wb_q.addr;
    assign wb_we       = wb_q.we;
    assign wb_carry    = wb_q.carry;
    assign br_taken    = wb_q.br;
    assign wb_err      = wb_q.err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU and random write-back back-pressure.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int TIMEOUT = 31;

    logic        clk;
    logic        reset;
    logic        inst_valid;
    logic        inst_ready;
    logic [11:0] decinst;
    logic [31:0] rs1_data, rs2_data, imm_data;
    logic [4:0]  rd_addr;
    logic        alu_en;
    logic [11:0] alu_decinst;
    logic [31:0] alu_rs1, alu_rs2, alu_imm;
    logic [31:0] alu_rd;
    logic        alu_cmp, alu_carry, alu_is_rd, alu_is_inst;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        wb_we, wb_carry, br_taken, wb_err;

    alu_issue_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .decinst(decinst), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm_data(imm_data), .rd_addr(rd_addr),
        .alu_en(alu_en), .alu_decinst(alu_decinst),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm),
        .alu_rd(alu_rd), .alu_cmp(alu_cmp), .alu_carry(alu_carry),
        .alu_is_rd(alu_is_rd), .alu_is_inst(alu_is_inst),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_addr(wb_addr), .wb_we(wb_we),
        .wb_carry(wb_carry), .br_taken(br_taken), .wb_err(wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        cmp;
        logic        carry;
        logic        br;
        logic        known;
        int          lat_inst;
        int          lat_rd;
    } alu_out_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        we;
        logic        carry;
        logic        br;
        logic        err;
        int          exec_cyc;
    } exp_t;

    localparam logic [11:0] OPS [27] = '{
        DI_ADD, DI_SUB, DI_SLL, DI_SLT, DI_SLTU, DI_XOR, DI_SRL, DI_SRA, DI_OR, DI_AND,
        DI_ADDI, DI_SLTI, DI_SLTIU, DI_XORI, DI_ORI, DI_ANDI, DI_SLLI, DI_SRLI, DI_SRAI,
        DI_BEQ, DI_BNE, DI_BLT, DI_BGE, DI_BLTU, DI_BGEU, DI_LUI, DI_AUIPC};

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   hold_n = 0;
    int   en_cyc = 0;

    // Behaviour of a real ALU: 2 cycles to prime, shifters retire 2 bits per cycle after that
    function automatic alu_out_t alu_ref(input logic [11:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] imm);
        alu_out_t r;
        logic [32:0] s;
        r = '0;
        r.known = 1'b1;
        r.lat_inst = 2;
        r.lat_rd = 2;
        s = {1'b0, a} + {1'b0, b};
        case (op)
            DI_ADD:   begin r.res = s[31:0]; r.carry = s[32]; end
            DI_SUB:   r.res = a - b;
            DI_SLL:   begin r.res = a << b[4:0]; r.lat_rd = 2 + int'(b[4:0]) / 2; end
            DI_SLT:   r.res = {31'd0, $signed(a) < $signed(b)};
            DI_SLTU:  r.res = {31'd0, a < b};
            DI_XOR:   r.res = a ^ b;
            DI_SRL:   begin r.res = a >> b[4:0]; r.lat_rd = 2 + int'(b[4:0]) / 2; end
            DI_SRA:   begin r.res = $signed(a) >>> b[4:0]; r.lat_rd = 2 + int'(b[4:0]) / 2; end
            DI_OR:    r.res = a | b;
            DI_AND:   r.res = a & b;
            DI_ADDI:  begin s = {1'b0, a} + {1'b0, imm}; r.res = s[31:0]; r.carry = s[32]; end
            DI_SLTI:  r.res = {31'd0, $signed(a) < $signed(imm)};
            DI_SLTIU: r.res = {31'd0, a < imm};
            DI_XORI:  r.res = a ^ imm;
            DI_ORI:   r.res = a | imm;
            DI_ANDI:  r.res = a & imm;
            DI_SLLI:  begin r.res = a << imm[4:0]; r.lat_rd = 2 + int'(imm[4:0]) / 2; end
            DI_SRLI:  begin r.res = a >> imm[4:0]; r.lat_rd = 2 + int'(imm[4:0]) / 2; end
            DI_SRAI:  begin r.res = $signed(a) >>> imm[4:0]; r.lat_rd = 2 + int'(imm[4:0]) / 2; end
            DI_BEQ:   begin r.br = 1'b1; r.cmp = (a == b); end
            DI_BNE:   begin r.br = 1'b1; r.cmp = (a != b); end
            DI_BLT:   begin r.br = 1'b1; r.cmp = ($signed(a) < $signed(b)); end
            DI_BGE:   begin r.br = 1'b1; r.cmp = ($signed(a) >= $signed(b)); end
            DI_BLTU:  begin r.br = 1'b1; r.cmp = (a < b); end
            DI_BGEU:  begin r.br = 1'b1; r.cmp = (a >= b); end
            DI_LUI:   r.res = imm;
            DI_AUIPC: r.res = a + imm;
            default:  r.known = 1'b0;
        endcase
        return r;
    endfunction

    function automatic exp_t expect_of(input logic [11:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] imm,
                                       input logic [4:0] rd);
        exp_t e;
        alu_out_t r;
        r = alu_ref(op, a, b, imm);
        e = '0;
        e.addr = rd;
        if (!r.known) begin
            e.err = 1'b1;
            e.exec_cyc = TIMEOUT + 1;
        end else if (r.br) begin
            e.br = r.cmp;
            e.carry = r.carry;
            e.exec_cyc = r.lat_inst;
        end else begin
            e.data = r.res;
            e.we = (rd != 5'd0);
            e.carry = r.carry;
            e.exec_cyc = r.lat_rd;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ALU model: tri-states alu_rd whenever it is not presenting a result
    initial begin
        int m_cnt;
        alu_out_t r;
        m_cnt = 0;
        alu_rd = 'z; alu_cmp = 0; alu_carry = 0; alu_is_rd = 0; alu_is_inst = 0;
        forever begin
            @(negedge clk);
            if (!alu_en) begin
                m_cnt = 0;
                alu_rd = 'z; alu_cmp = 0; alu_carry = 0; alu_is_rd = 0; alu_is_inst = 0;
            end else begin
                m_cnt++;
                r = alu_ref(alu_decinst, alu_rs1, alu_rs2, alu_imm);
                if (r.known && m_cnt >= r.lat_inst) begin
                    alu_is_inst = 1'b1;
                    if (r.br) alu_cmp = r.cmp;
                end
                if (r.known && !r.br && m_cnt >= r.lat_rd) begin
                    alu_is_rd = 1'b1;
                    alu_rd = r.res;
                    alu_carry = r.carry;
                end
            end
        end
    end

    // Monitor: compares every cycle wb_valid is up, pops on handshake
    initial begin
        exp_t e;
        wb_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (alu_en) en_cyc++;
            else if (!wb_valid) en_cyc = 0;
            if (wb_valid && hold_n > 0) begin
                wb_ready = 1'b0;
                hold_n--;
            end else begin
                wb_ready = ($urandom_range(3) != 0);
            end
            if (wb_valid) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_wb_valid");
                end else begin
                    e = sb[0];
                    chk("wb_data", wb_data, e.data);
                    chk("wb_addr", 32'(wb_addr), 32'(e.addr));
                    chk("wb_we", 32'(wb_we), 32'(e.we));
                    chk("wb_carry", 32'(wb_carry), 32'(e.carry));
                    chk("br_taken", 32'(br_taken), 32'(e.br));
                    chk("wb_err", 32'(wb_err), 32'(e.err));
                    if (!wb_ready) chk("inst_ready_in_done", 32'(inst_ready), 32'd0);
                    if (wb_ready) begin
                        chk("exec_cycles", 32'(en_cyc), 32'(e.exec_cyc));
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic issue(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [4:0] rd);
        int guard;
        @(negedge clk);
        decinst = op; rs1_data = a; rs2_data = b; imm_data = imm; rd_addr = rd;
        inst_valid = 1'b1;
        guard = 0;
        while (!inst_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!inst_ready) begin
            fail_now("accept_wait");
            inst_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back(expect_of(op, a, b, imm, rd));
        #1;
        inst_valid = 1'b0;
        decinst = 12'($urandom); rs1_data = $urandom; rs2_data = $urandom;
        imm_data = $urandom; rd_addr = 5'($urandom);
        @(negedge clk);
        chk("alu_en_load", 32'(alu_en), 32'd0);
        @(negedge clk);
        chk("alu_en_exec", 32'(alu_en), 32'd1);
        chk("alu_decinst", 32'(alu_decinst), 32'(op));
        chk("alu_rs1", alu_rs1, a);
        chk("alu_rs2", alu_rs2, b);
        chk("alu_imm", alu_imm, imm);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            fail_now("drain_wait");
            sb.delete();
        end
    endtask

    initial begin
        logic [31:0] a, b;
        reset = 1'b0; inst_valid = 1'b0;
        decinst = '0; rs1_data = '0; rs2_data = '0; imm_data = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_inst_ready", 32'(inst_ready), 32'd1);
        chk("rst_alu_en", 32'(alu_en), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_err", 32'(wb_err), 32'd0);
        reset = 1'b1;

        issue(DI_ADD, 32'd5, 32'd7, 32'd0, 5'd3);
        drain();
        issue(DI_BEQ, 32'hA5, 32'hA5, 32'd0, 5'd1);
        issue(DI_BEQ, 32'hA5, 32'hA4, 32'd0, 5'd1);
        drain();
        issue(DI_SLLI, 32'd1, 32'd0, 32'd31, 5'd9);
        drain();
        issue(12'hFFF, 32'd1, 32'd2, 32'd3, 5'd4);
        drain();
        hold_n = 5;
        issue(DI_ADD, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd0);
        drain();

        issue(DI_SRA, 32'h8000_0000, 32'd20, 32'd0, 5'd7);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_alu_en", 32'(alu_en), 32'd0);
        chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
        chk("midrst_inst_ready", 32'(inst_ready), 32'd1);
        reset = 1'b1;
        issue(DI_ADD, 32'd100, 32'd23, 32'd0, 5'd12);
        drain();

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = ($urandom_range(3) == 0) ? a : $urandom;
            issue(OPS[$urandom_range(26)], a, b, $urandom, 5'($urandom_range(31)));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
